// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential word-address reads, buffers responses
// in a 2-entry FIFO towards decode, handles redirects and a sticky HALT.
module instr_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_oen,
    input  logic [DATA_WIDTH-1:0] im_dataout,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic                  halt
);

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 25;
    localparam logic [6:0]  HALT_OPC = 7'h7F;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  halt_pending_q, halt_pending_d;
    logic                  halt_q, halt_d;
    entry_t                fifo_q [2];

    entry_t                head_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  issue_c;
    logic [2:0]            occ_c;

    assign head_c   = fifo_q[rd_ptr_q];
    assign id_valid = rst_n & (count_q != 2'd0);
    assign id_instr = head_c.instr;
    assign id_pc    = head_c.pc;
    assign im_addr  = pc_q;
    assign im_oen   = ~issue_c;
    assign halt     = halt_q;

    // Issue when the FIFO can hold everything already owed plus one more response.
    always_comb begin
        pop_c   = id_valid & id_ready & ~redirect;
        push_c  = rst_n & inflight_q & ~redirect;
        occ_c   = 3'(count_q) + 3'(inflight_q) - 3'(pop_c);
        issue_c = rst_n & en & ~redirect & ~halt_pending_q & ~halt_q & (occ_c < 3'd2);

        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        inflight_d     = inflight_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        halt_pending_d = halt_pending_q;
        halt_d         = halt_q;

        if (redirect) begin
            pc_d           = redirect_pc;
            inflight_d     = 1'b0;
            count_d        = 2'd0;
            rd_ptr_d       = 1'b0;
            wr_ptr_d       = 1'b0;
            halt_pending_d = 1'b0;
        end else begin
            if (issue_c) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
            inflight_d = issue_c;
            req_pc_d   = pc_q;
            if (push_c) begin
                wr_ptr_d = ~wr_ptr_q;
                if (im_dataout[OPC_HI:OPC_LO] == HALT_OPC) begin
                    halt_pending_d = 1'b1;
                end
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
                if (head_c.instr[OPC_HI:OPC_LO] == HALT_OPC) begin
                    halt_d = 1'b1;
                end
            end
            count_d = count_q + 2'(push_c) - 2'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            req_pc_q       <= RESET_PC;
            inflight_q     <= 1'b0;
            count_q        <= 2'd0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            halt_pending_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            inflight_q     <= inflight_d;
            count_q        <= count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            halt_pending_q <= halt_pending_d;
            halt_q         <= halt_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= {im_dataout, req_pc_q};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for streaming/stall, plus hand
// sequences for redirect, en toggling, mid-stream reset and HALT.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] im_addr;
    logic        im_oen;
    logic [31:0] im_dataout;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halt;

    int n_chk  = 0;
    int n_fail = 0;
    logic        halt_en = 1'b0;
    logic [31:0] exp_req  = 32'd0;
    logic [31:0] exp_next = 32'd0;

    instr_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .im_addr    (im_addr),
        .im_oen     (im_oen),
        .im_dataout (im_dataout),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (halt_en && a == 32'd5) return 32'hFE00_0000;
        return a + 32'd100;
    endfunction

    // Synchronous memory: data for a request appears in the following cycle.
    always @(posedge clk) begin
        if (!im_oen) im_dataout <= word(im_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, then check request ordering and pop ordering.
    task automatic step(input logic e, input logic rdy, input logic rd, input logic [31:0] rpc,
                        input logic rn);
        @(negedge clk);
        en = e; id_ready = rdy; redirect = rd; redirect_pc = rpc; rst_n = rn;
        #1;
        if (!rn) begin
            chk("reset_oen", 64'(im_oen), 64'd1);
            chk("reset_valid", 64'(id_valid), 64'd0);
            exp_req  = 32'd0;
            exp_next = 32'd0;
        end else if (rd) begin
            chk("redirect_oen", 64'(im_oen), 64'd1);
            exp_req  = rpc;
            exp_next = rpc;
        end else begin
            if (!e) chk("en0_oen", 64'(im_oen), 64'd1);
            if (!im_oen) begin
                chk("req_addr", 64'(im_addr), 64'(exp_req));
                exp_req = exp_req + 32'd1;
            end
            if (id_valid && rdy) begin
                chk("pop_pc", 64'(id_pc), 64'(exp_next));
                chk("pop_instr", 64'(id_instr), 64'(word(exp_next)));
                exp_next = exp_next + 32'd1;
            end
        end
    endtask

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        oen;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [14];

    initial begin
        rst_n = 1'b0; en = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;

        //            rstn  rdy   oen   addr   valid pc
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'd1, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd2, 1'b1, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 32'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd4, 1'b1, 32'd2};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'd5, 1'b1, 32'd3};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'd6, 1'b1, 32'd4};

        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

        // Streaming from reset with a decode stall in cycles 3-8.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, vecs[i].rdy, 1'b0, 32'd0, vecs[i].rstn);
            chk($sformatf("tbl%0d_oen", i), 64'(im_oen), 64'(vecs[i].oen));
            chk($sformatf("tbl%0d_addr", i), 64'(im_addr), 64'(vecs[i].addr));
            chk($sformatf("tbl%0d_valid", i), 64'(id_valid), 64'(vecs[i].valid));
            chk($sformatf("tbl%0d_halt", i), 64'(halt), 64'd0);
            if (vecs[i].valid) begin
                chk($sformatf("tbl%0d_pc", i), 64'(id_pc), 64'(vecs[i].pc));
                chk($sformatf("tbl%0d_instr", i), 64'(id_instr), 64'(vecs[i].pc + 32'd100));
            end
        end

        // Redirect while a head entry is buffered and a request is in flight.
        step(1'b1, 1'b0, 1'b1, 32'd40, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("redir_valid0_a", 64'(id_valid), 64'd0);
        chk("redir_addr40", 64'(im_addr), 64'd40);
        chk("redir_oen40", 64'(im_oen), 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("redir_valid0_b", 64'(id_valid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("redir_valid1", 64'(id_valid), 64'd1);
        chk("redir_pc40", 64'(id_pc), 64'd40);
        chk("redir_instr140", 64'(id_instr), 64'd140);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

        // en toggling every cycle: requests only on en=1 cycles.
        for (int i = 0; i < 16; i++) begin
            step(((i % 2) == 0), 1'b1, 1'b0, 32'd0, 1'b1);
            chk($sformatf("entog%0d_oen", i), 64'(im_oen), 64'((i % 2) != 0));
        end

        // One-cycle reset mid-stream discards buffered/in-flight words.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("rst_valid0", 64'(id_valid), 64'd0);
        chk("rst_halt0", 64'(halt), 64'd0);
        chk("rst_oen", 64'(im_oen), 64'd0);
        chk("rst_addr0", 64'(im_addr), 64'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

        // HALT at PC 5: last request is PC 6, halt rises after PC 5 is popped.
        halt_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        for (int c = 0; c < 15; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            chk($sformatf("halt_c%0d_oen", c), 64'(im_oen), 64'(c >= 7));
            chk($sformatf("halt_c%0d_halt", c), 64'(halt), 64'(c >= 8));
        end
        step(1'b1, 1'b1, 1'b1, 32'd40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            chk($sformatf("halt_redir%0d_halt", i), 64'(halt), 64'd1);
            chk($sformatf("halt_redir%0d_oen", i), 64'(im_oen), 64'd1);
        end

        // Only reset clears halt.
        halt_en = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("unhalt_halt0", 64'(halt), 64'd0);
        chk("unhalt_valid0", 64'(id_valid), 64'd0);
        chk("unhalt_oen", 64'(im_oen), 64'd0);
        chk("unhalt_addr0", 64'(im_addr), 64'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
